// File: rtl/monolith_bricks_if.sv
// Start/result bundle for the bricks stage: the sequencer drives start and
// state_in, and the bricks block returns state_out, valid and busy.
interface monolith_bricks_if #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16
);
    logic                  start;
    logic [WORD_WIDTH-1:0] state_in  [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] state_out [0:STATE_SIZE-1];
    logic                  valid;
    logic                  busy;

    modport master (output start, state_in, input state_out, valid, busy);
    modport slave  (input start, state_in, output state_out, valid, busy);
endinterface

// File: rtl/monolith_bricks.sv
// Bricks layer over GF(2^WORD_WIDTH - 1): out[i] = in[i] + in[i-1]^2.
// One element per cycle through a single shared squarer.
//
// state   | meaning
// IDLE    | waiting for the first start after reset
// COMPUTE | writing state_out[idx], one element per cycle
// DONE    | result held with valid=1; a new start restarts
module monolith_bricks #(
    parameter int          WORD_WIDTH = 31,
    parameter int          STATE_SIZE = 16,
    parameter logic [31:0] PRIME      = 32'h7FFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    monolith_bricks_if.slave   bus
);
    localparam int                    IDX_W = (STATE_SIZE > 2) ? $clog2(STATE_SIZE) : 1;
    localparam logic [IDX_W-1:0]      LAST  = IDX_W'(STATE_SIZE - 1);
    localparam logic [WORD_WIDTH-1:0] PW    = WORD_WIDTH'(PRIME);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [WORD_WIDTH-1:0]  lat [0:STATE_SIZE-1];

    logic [IDX_W-1:0]        idx_prev;
    logic [WORD_WIDTH-1:0]   op_a, op_b, sq, sum_fold, res;
    logic [2*WORD_WIDTH-1:0] op_a_ext, prod;
    logic [WORD_WIDTH:0]     fold1, sum;

    // The only non-canonical WORD_WIDTH-bit value is PRIME itself
    function automatic logic [WORD_WIDTH-1:0] canon(input logic [WORD_WIDTH-1:0] x);
        return (x == PW) ? '0 : x;
    endfunction

    always_comb begin
        idx_prev = idx - 1'b1;
        op_a     = lat[idx_prev];
        op_b     = lat[idx];
        op_a_ext = {{WORD_WIDTH{1'b0}}, op_a};
        prod     = op_a_ext * op_a_ext;
        fold1    = {1'b0, prod[WORD_WIDTH-1:0]} + {1'b0, prod[2*WORD_WIDTH-1:WORD_WIDTH]};
        // fold1 - PRIME always fits in WORD_WIDTH bits when fold1 >= PRIME
        sq       = (fold1 >= {1'b0, PW}) ? (fold1[WORD_WIDTH-1:0] - PW) : fold1[WORD_WIDTH-1:0];
        sum      = {1'b0, sq} + {1'b0, op_b};
        sum_fold = sum[WORD_WIDTH-1:0] + WORD_WIDTH'(sum[WORD_WIDTH]);
        res      = canon(sum_fold);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            for (int i = 0; i < STATE_SIZE; i++) begin
                lat[i]           <= '0;
                bus.state_out[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int i = 0; i < STATE_SIZE; i++) begin
                            lat[i] <= canon(bus.state_in[i]);
                        end
                        bus.state_out[0] <= canon(bus.state_in[0]);
                        idx       <= IDX_W'(1);
                        bus.valid <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    bus.state_out[idx] <= res;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        bus.valid <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_monolith_bricks.sv
// Scoreboard bench for monolith_bricks: expected results are queued at start
// time from an arithmetic model and popped by a monitor on each valid rise.
module tb_monolith_bricks;
    localparam int WW = 31;
    localparam int SS = 16;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    typedef logic [SS-1:0][WW-1:0] vec_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    vec_t exp_q[$];
    int   acc_q[$];

    monolith_bricks_if #(.WORD_WIDTH(WW), .STATE_SIZE(SS)) bus();

    monolith_bricks #(.WORD_WIDTH(WW), .STATE_SIZE(SS), .PRIME(32'h7FFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t model(input vec_t v);
        vec_t r;
        longint unsigned a, b;
        r[0] = WW'(longint'(v[0]) % P);
        for (int i = 1; i < SS; i++) begin
            a = longint'(v[i-1]) % P;
            b = longint'(v[i]) % P;
            r[i] = WW'((b + a * a) % P);
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        int sel = $urandom_range(0, 7);
        case (sel)
            0: return '0;
            1: return WW'(P);
            2: return WW'(P - 1);
            default: return WW'($urandom);
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < SS; i++) v[i] = rand_word();
        return v;
    endfunction

    // Monitor: compares on every rising edge of valid
    logic valid_q = 1'b0;
    logic busy_q  = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        vec_t e;
        int   a;
        if (bus.busy) busy_cnt = busy_q ? busy_cnt + 1 : 1;
        if (bus.valid && !valid_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_valid: valid rose at cycle %0d with no outstanding start", cyc);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                for (int i = 0; i < SS; i++) begin
                    checks++;
                    if (bus.state_out[i] !== e[i]) begin
                        failures++;
                        $display("FAIL out[%0d]: got %h expected %h", i, bus.state_out[i], e[i]);
                    end
                end
                checks++;
                if (cyc - a != SS - 1) begin
                    failures++;
                    $display("FAIL latency: got %0d expected %0d", cyc - a, SS - 1);
                end
                checks++;
                if (busy_cnt != SS - 1) begin
                    failures++;
                    $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, SS - 1);
                end
            end
        end
        valid_q = bus.valid;
        busy_q  = bus.busy;
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_cleared(input string name);
        logic any;
        any = 1'b0;
        for (int i = 0; i < SS; i++) if (bus.state_out[i] !== '0) any = 1'b1;
        check_bit({name, "_valid"}, bus.valid, 1'b0);
        check_bit({name, "_busy"}, bus.busy, 1'b0);
        check_bit({name, "_out_nonzero"}, any, 1'b0);
    endtask

    task automatic drive_start(input vec_t v, input bit accept);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < SS; i++) bus.state_in[i] = v[i];
        @(negedge clk);
        bus.start = 1'b0;
        if (accept) begin
            exp_q.push_back(model(v));
            acc_q.push_back(cyc);
            check_bit("busy_after_start", bus.busy, 1'b1);
            check_bit("valid_drop_after_start", bus.valid, 1'b0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.valid !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: valid=%b after %0d cycles, required 1", bus.valid, n);
        end
    endtask

    initial begin
        vec_t v, w;
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < SS; i++) bus.state_in[i] = '0;
        #3;
        check_cleared("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // all zero
        v = '0;
        drive_start(v, 1'b1);
        wait_done();

        // in[i] = i
        for (int i = 0; i < SS; i++) v[i] = WW'(i);
        drive_start(v, 1'b1);
        wait_done();

        // all -1
        for (int i = 0; i < SS; i++) v[i] = WW'(P - 1);
        drive_start(v, 1'b1);
        wait_done();

        // reduction corner
        v = '0;
        v[14] = 31'h4000_0000;
        v[15] = 31'h6000_0000;
        drive_start(v, 1'b1);
        wait_done();

        // PRIME inputs read as zero
        for (int i = 0; i < SS; i++) v[i] = WW'(P);
        drive_start(v, 1'b1);
        wait_done();

        // start re-pulsed mid-compute and state_in churn are ignored
        v = rand_vec();
        drive_start(v, 1'b1);
        repeat (3) @(negedge clk);
        w = rand_vec();
        drive_start(w, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < SS; i++) bus.state_in[i] = rand_word();
        end
        wait_done();

        // restart from DONE
        drive_start(rand_vec(), 1'b1);
        wait_done();

        // asynchronous reset mid-compute
        drive_start(rand_vec(), 1'b1);
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_cleared("async_reset");
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_bit("no_valid_after_abort", bus.valid, 1'b0);
        drive_start(rand_vec(), 1'b1);
        wait_done();

        // randomized back-to-back
        for (int t = 0; t < 20; t++) begin
            drive_start(rand_vec(), 1'b1);
            wait_done();
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/monolith_bricks.md
MONOLITH_BRICKS -- requirements
Module: monolith_bricks

Interface
REQ-001 Parameter WORD_WIDTH, default 31, SHALL be the field element width in bits.
REQ-002 Parameter STATE_SIZE, default 16, SHALL be the number of state words; legal range is 2..64.
REQ-003 Parameter PRIME, default 32'h7FFF_FFFF (M31), SHALL be the field modulus; the datapath SHALL support only PRIME = 2^WORD_WIDTH - 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  input  1  SHALL request a new bricks computation on state_in.
REQ-007 state_in  input  WORD_WIDTH x [0:STATE_SIZE-1] unpacked  SHALL be the input state; it is sampled only on the accepting start edge.
REQ-008 state_out  output  WORD_WIDTH x [0:STATE_SIZE-1] unpacked  SHALL be the registered result state, which feeds the concrete (MDS) stage.
REQ-009 valid  output  1  SHALL indicate that state_out holds a complete result.
REQ-010 busy  output  1  SHALL be high while a computation is in progress.

Function
REQ-011 The block SHALL compute out[0] = in[0] and, for i = 1..STATE_SIZE-1, out[i] = (in[i] + in[i-1]^2) mod PRIME, using the original latched inputs for every term.
REQ-012 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL latch state_in into an internal copy, write out[0] = latched in[0] reduced mod PRIME, set the index to 1, deassert valid, and enter COMPUTE.
REQ-014 In COMPUTE, each cycle SHALL write exactly one element state_out[idx] and increment idx; this uses one shared squarer.
REQ-015 On the edge that writes idx = STATE_SIZE-1, the FSM SHALL enter DONE and set valid=1; valid is therefore first high STATE_SIZE-1 cycles after the accepting start edge (15 cycles at the defaults).
REQ-016 In COMPUTE, start SHALL be ignored, and state_in changes SHALL have no effect.
REQ-017 In DONE, valid SHALL remain 1 and state_out SHALL hold its value until the next accepted start.
REQ-018 busy SHALL be 1 exactly while in COMPUTE.
REQ-019 Modular reduction: the 2*WORD_WIDTH-bit square p SHALL be folded as p[WW-1:0] + p[2WW-1:WW], followed by a conditional subtract of PRIME.
REQ-020 The reduced square plus in[i] SHALL then be reduced again with a carry fold and a conditional subtract, so the result is always canonical (< PRIME).
REQ-021 An input word equal to PRIME SHALL be treated as 0; all outputs SHALL be canonical.
REQ-022 Elements of state_out not yet written in COMPUTE SHALL retain their previous values; consumers use them only when valid=1.

Reset
REQ-023 While reset=0, the FSM SHALL be IDLE, idx = 0, valid = 0, busy = 0, and every state_out word and internal latched word SHALL be 0, regardless of clk.
REQ-024 Reset asserted mid-COMPUTE SHALL abort the computation immediately; after release the block SHALL wait in IDLE for a new start, with no spurious valid.

Verification
REQ-025 All-zero input, start pulse -> valid rises 15 cycles later; all state_out words = 0; busy high for exactly 15 cycles.
REQ-026 in[i] = i for i = 0..15 -> out[0] = 0; out[i] = i + (i-1)^2 (e.g. out[1] = 1, out[15] = 211).
REQ-027 All in[i] = 0x7FFFFFFE (-1) -> out[0] = 0x7FFFFFFE; out[1..15] = 0 (since -1 + 1 = 0).
REQ-028 Reduction corner: in[14] = 0x40000000, in[15] = 0x60000000, all others 0 -> out[15] = 1 (2^60 mod p = 2^29; 2^29 + 3*2^29 = 2^31 ≡ 1), out[14] = 0x40000000.
REQ-029 start re-pulsed at cycle 5 of COMPUTE with a different state_in -> ignored; the result matches the first input.
REQ-029 (cont.) A later start in DONE drops valid on the next edge and produces the second result 15 cycles later.
REQ-030 reset driven low at cycle 7 of COMPUTE, asynchronously between edges -> outputs clear immediately; no valid follows; a subsequent start produces a correct result.
